// File: rtl/johnson_sequence_controller_pkg.sv
// ---------------------------------------------------------------------------
// johnson_sequence_controller_pkg
//   Shared definitions for the Johnson ring sequencer:
//     - state_e      : controller states (IDLE / RUN / STEP)
//     - STATE_W      : width of the state encoding
//     - phase_width(): phase index width for a ring of a given length
// ---------------------------------------------------------------------------
package johnson_sequence_controller_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  // A ring of `width` bits walks through 2*width codes.
  function automatic int phase_width(input int width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/johnson_sequence_controller_phase_decoder.sv
// ---------------------------------------------------------------------------
// johnson_sequence_controller_phase_decoder
//   Purely combinational. Converts a Johnson ring value into its binary
//   phase index and reports whether the value is a legal Johnson code.
//
// Ports
//   q_i      in   WIDTH     ring value
//   phase_o  out  PHASE_W   phase index 0..2*WIDTH-1 (meaningless for illegal codes)
//   legal_o  out  1         1 when q_i is one of the 2*WIDTH legal codes
// ---------------------------------------------------------------------------
module johnson_sequence_controller_phase_decoder
  import johnson_sequence_controller_pkg::*;
#(
  parameter  int WIDTH   = 8,
  localparam int PHASE_W = phase_width(WIDTH)
) (
  input  logic [WIDTH-1:0]   q_i,
  output logic [PHASE_W-1:0] phase_o,
  output logic               legal_o
);

  logic [PHASE_W-1:0] ones;
  logic [WIDTH-1:0]   x;

  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + PHASE_W'(q_i[i]);
    end

    // First half of the sequence fills with ones from the LSB (phase = ones);
    // second half drains them from the LSB (phase = 2W - ones).
    if (q_i[WIDTH-1]) begin
      phase_o = PHASE_W'(2 * WIDTH - int'(ones));
    end else begin
      phase_o = ones;
    end

    // Normalise to the "filling" half; a legal code is then a contiguous run
    // of ones anchored at bit 0, i.e. x is of the form 2^k - 1.
    x       = q_i[WIDTH-1] ? ~q_i : q_i;
    legal_o = ((x & (x + WIDTH'(1))) == '0);
  end

endmodule

// File: rtl/johnson_sequence_controller.sv
// ---------------------------------------------------------------------------
// johnson_sequence_controller
//   Owns an 8-bit (WIDTH) Johnson ring and sequences it under run/stop/step/
//   clear commands with a direction select. Decodes the ring to a phase
//   index, counts full revolutions, and optionally recovers from illegal
//   ring codes.
//
// Optional feature macro: JSC_ILLEGAL_RECOVERY_EN
//   defined     : an illegal ring code forces q to 0 and the FSM to IDLE on
//                 the next edge (above clear in priority); illegal_flag
//                 pulses for one cycle; rev_count is left unchanged.
//   not defined : no recovery; illegal_flag is constant 0.
//
// Ports
//   clk          in   1        rising-edge clock
//   reset        in   1        asynchronous active-low reset
//   clear        in   1        sync clear: q=0, rev_count=0, IDLE
//   start        in   1        IDLE -> RUN
//   stop         in   1        any state -> IDLE, suppresses advance
//   step         in   1        IDLE -> STEP (one advance, then IDLE)
//   dir          in   1        0 forward, 1 reverse; sampled on each advance
//   q            out  WIDTH    ring value
//   phase        out  PHASE_W  phase index, combinational from q
//   busy         out  1        state != IDLE
//   rev_count    out  REV_W    completed revolutions, wraps silently
//   rev_done     out  1        one-cycle pulse per revolution wrap
//   illegal_flag out  1        one-cycle pulse per illegal-code recovery
//   dbg_state_o  out  state_e  current FSM state, for observation only
//
// Commands are level-sampled on every rising edge with fixed priority
// clear > stop > start > step; there is no handshake, every sampled command
// takes effect on that edge.
// ---------------------------------------------------------------------------
module johnson_sequence_controller
  import johnson_sequence_controller_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int REV_W   = 8,
  localparam int PHASE_W = phase_width(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               start,
  input  logic               stop,
  input  logic               step,
  input  logic               dir,
  output logic [WIDTH-1:0]   q,
  output logic [PHASE_W-1:0] phase,
  output logic               busy,
  output logic [REV_W-1:0]   rev_count,
  output logic               rev_done,
  output logic               illegal_flag,
  output state_e             dbg_state_o
);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(2 * WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [REV_W-1:0]   rev_q, rev_d;
  logic               rev_done_q, rev_done_d;
  logic               illegal_q, illegal_d;

  logic [WIDTH-1:0]   q_fwd, q_rev;
  logic [PHASE_W-1:0] phase_cur;
  logic               legal;
  logic               wrap;
  logic               advance;

  johnson_sequence_controller_phase_decoder #(
    .WIDTH (WIDTH)
  ) u_phase_decoder (
    .q_i     (q_q),
    .phase_o (phase_cur),
    .legal_o (legal)
  );

  assign q_fwd = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
  assign q_rev = {~q_q[0], q_q[WIDTH-1:1]};

  // A revolution completes when the advance crosses the 2W-1 <-> 0 seam.
  assign wrap = dir ? (phase_cur == '0) : (phase_cur == PHASE_LAST);

  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    rev_d      = rev_q;
    rev_done_d = 1'b0;
    illegal_d  = 1'b0;
    advance    = 1'b0;

    if (clear) begin
      state_d = ST_IDLE;
      q_d     = '0;
      rev_d   = '0;
    end else if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
          end else if (step) begin
            state_d = ST_STEP;
          end
        end
        ST_RUN: begin
          advance = 1'b1;
        end
        ST_STEP: begin
          advance = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (advance) begin
      q_d = dir ? q_rev : q_fwd;
      if (wrap) begin
        rev_d      = rev_q + REV_W'(1);
        rev_done_d = 1'b1;
      end
    end

`ifdef JSC_ILLEGAL_RECOVERY_EN
    // Recovery overrides every command, including clear, but keeps the
    // revolution count intact.
    if (!legal) begin
      state_d    = ST_IDLE;
      q_d        = '0;
      rev_d      = rev_q;
      rev_done_d = 1'b0;
      illegal_d  = 1'b1;
    end
`endif
  end

`ifndef JSC_ILLEGAL_RECOVERY_EN
  logic unused_legal;
  assign unused_legal = legal;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      q_q        <= '0;
      rev_q      <= '0;
      rev_done_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      rev_q      <= rev_d;
      rev_done_q <= rev_done_d;
      illegal_q  <= illegal_d;
    end
  end

  assign q            = q_q;
  assign phase        = phase_cur;
  assign busy         = (state_q != ST_IDLE);
  assign rev_count    = rev_q;
  assign rev_done     = rev_done_q;
  assign illegal_flag = illegal_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_johnson_sequence_controller.sv
module tb_johnson_sequence_controller;
  import johnson_sequence_controller_pkg::*;

  localparam int W  = 8;
  localparam int RW = 8;
  localparam int PW = 4;
  localparam int N  = 2 * W;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          reset, clear, start, stop, step, dir;
  logic [W-1:0]  q;
  logic [PW-1:0] phase;
  logic          busy;
  logic [RW-1:0] rev_count;
  logic          rev_done, illegal_flag;
  state_e        dbg_state;

  johnson_sequence_controller #(.WIDTH(W), .REV_W(RW)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .start        (start),
    .stop         (stop),
    .step         (step),
    .dir          (dir),
    .q            (q),
    .phase        (phase),
    .busy         (busy),
    .rev_count    (rev_count),
    .rev_done     (rev_done),
    .illegal_flag (illegal_flag),
    .dbg_state_o  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: tracks the phase as a plain integer and derives the
  // ring value from it.
  int   m_phase;
  int   m_mode;
  int   m_rev;
  logic m_rev_done;

  function automatic logic [W-1:0] ring_of(input int p);
    int v;
    if (p <= W) v = (1 << p) - 1;
    else        v = ~((1 << (p - W)) - 1);
    return v[W-1:0];
  endfunction

  function automatic void model_reset();
    m_phase    = 0;
    m_mode     = M_IDLE;
    m_rev      = 0;
    m_rev_done = 1'b0;
  endfunction

  function automatic void model_advance(input logic d);
    if (!d) begin
      if (m_phase == N - 1) begin m_rev = (m_rev + 1) % 256; m_rev_done = 1'b1; end
      m_phase = (m_phase + 1) % N;
    end else begin
      if (m_phase == 0) begin m_rev = (m_rev + 1) % 256; m_rev_done = 1'b1; end
      m_phase = (m_phase + N - 1) % N;
    end
  endfunction

  function automatic void model_edge(input logic c, s, t, sp, d);
    m_rev_done = 1'b0;
    if (c) begin
      m_phase = 0; m_rev = 0; m_mode = M_IDLE;
    end else if (t) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_RUN) begin
      model_advance(d);
    end else if (m_mode == M_STEP) begin
      model_advance(d);
      m_mode = M_IDLE;
    end else if (s) begin
      m_mode = M_RUN;
    end else if (sp) begin
      m_mode = M_STEP;
    end
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1; drives inputs, takes one edge, returns at posedge+1.
  task automatic tick(input logic c, s, t, sp, d);
    clear = c; start = s; stop = t; step = sp; dir = d;
    @(posedge clk);
    model_edge(c, s, t, sp, d);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; clear = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0; dir = 1'b0;
    model_reset();
    #2;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h want 00", q); end
    checks++; if (rev_count !== 8'd0) begin errors++; $display("FAIL reset_rev: got %0d want 0", rev_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (rev_done !== 1'b0 || illegal_flag !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: rev_done=%b illegal=%b want 0 0", rev_done, illegal_flag);
    end
    checks++; if (phase !== 4'd0) begin errors++; $display("FAIL reset_phase: got %0d want 0", phase); end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_forward_run();
    int wraps = 0;
    int wrap_at = -1;
    tick(0, 1, 0, 0, 0);
    checks++; if (busy !== 1'b1 || q !== 8'h00) begin
      errors++; $display("FAIL fwd_start_latency: busy=%b q=%h want 1 00", busy, q);
    end
    for (int i = 0; i < N; i++) begin
      logic [W-1:0] e;
      tick(0, 0, 0, 0, 0);
      exp_q.push_back(ring_of(m_phase));
      e = exp_q.pop_front();
      checks++; if (q !== e) begin errors++; $display("FAIL fwd_q[%0d]: got %h want %h", i, q, e); end
      checks++; if (rev_done !== m_rev_done) begin
        errors++; $display("FAIL fwd_rev_done[%0d]: got %b want %b", i, rev_done, m_rev_done);
      end
      if (rev_done === 1'b1) begin wraps++; wrap_at = i; end
    end
    checks++; if (q !== 8'h00 || rev_count !== 8'd1) begin
      errors++; $display("FAIL fwd_end: q=%h rev=%0d want 00 1", q, rev_count);
    end
    checks++; if (wraps != 1 || wrap_at != N - 1) begin
      errors++; $display("FAIL fwd_wrap_once: wraps=%0d at=%0d want 1 at 15", wraps, wrap_at);
    end
    tick(0, 0, 1, 0, 0);
  endtask

  task automatic test_step();
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 0, 1, 0);
      checks++; if (busy !== 1'b1 || q !== ring_of(k)) begin
        errors++; $display("FAIL step_pending[%0d]: busy=%b q=%h want 1 %h", k, busy, q, ring_of(k));
      end
      tick(0, 0, 0, 0, 0);
      checks++; if (busy !== 1'b0 || q !== ring_of(k + 1)) begin
        errors++; $display("FAIL step_done[%0d]: busy=%b q=%h want 0 %h", k, busy, q, ring_of(k + 1));
      end
    end
    checks++; if (q !== 8'h07 || phase !== 4'd3) begin
      errors++; $display("FAIL step_final: q=%h phase=%0d want 07 3", q, phase);
    end
  endtask

  task automatic test_reverse();
    logic [W-1:0] rq [3];
    int           rp [3];
    rq[0] = 8'h80; rq[1] = 8'hC0; rq[2] = 8'hE0;
    rp[0] = 15;    rp[1] = 14;    rp[2] = 13;
    tick(1, 0, 0, 0, 0);
    checks++; if (q !== 8'h00 || rev_count !== 8'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rev_clear: q=%h rev=%0d busy=%b want 00 0 0", q, rev_count, busy);
    end
    tick(0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0, 1);
      checks++; if (q !== rq[i] || int'(phase) != rp[i]) begin
        errors++; $display("FAIL rev_seq[%0d]: q=%h phase=%0d want %h %0d", i, q, phase, rq[i], rp[i]);
      end
      checks++; if (rev_done !== (i == 0)) begin
        errors++; $display("FAIL rev_done[%0d]: got %b want %b", i, rev_done, (i == 0));
      end
    end
    checks++; if (rev_count !== 8'd1) begin errors++; $display("FAIL rev_count: got %0d want 1", rev_count); end
    tick(0, 0, 1, 0, 0);
  endtask

  task automatic test_stop_hold();
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0);
    checks++; if (q !== 8'h1F || phase !== 4'd5) begin
      errors++; $display("FAIL stop_pre: q=%h phase=%0d want 1F 5", q, phase);
    end
    tick(0, 0, 1, 0, 0);
    checks++; if (q !== 8'h1F || busy !== 1'b0) begin
      errors++; $display("FAIL stop_hold: q=%h busy=%b want 1F 0", q, busy);
    end
    tick(0, 1, 1, 0, 0);
    checks++; if (q !== 8'h1F || busy !== 1'b0) begin
      errors++; $display("FAIL start_stop: q=%h busy=%b want 1F 0", q, busy);
    end
    tick(0, 0, 0, 0, 0);
    checks++; if (q !== 8'h1F || busy !== 1'b0) begin
      errors++; $display("FAIL stop_idle: q=%h busy=%b want 1F 0", q, busy);
    end
  endtask

  task automatic test_reset_midrun();
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    for (int i = 0; i < N + 10; i++) tick(0, 0, 0, 0, 0);
    checks++; if (q !== 8'hFC || rev_count !== 8'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL midrun_pre: q=%h rev=%0d busy=%b want FC 1 1", q, rev_count, busy);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (q !== 8'h00 || rev_count !== 8'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrun_async: q=%h rev=%0d busy=%b want 00 0 0", q, rev_count, busy);
    end
    @(posedge clk); #1;
    checks++; if (q !== 8'h00 || busy !== 1'b0) begin
      errors++; $display("FAIL midrun_held: q=%h busy=%b want 00 0", q, busy);
    end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_rev_wrap();
    int pulses = 0;
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    for (int i = 0; i < 256 * N; i++) begin
      tick(0, 0, 0, 0, 0);
      if (rev_done === 1'b1) pulses++;
    end
    checks++; if (rev_count !== 8'd0 || pulses != 256) begin
      errors++; $display("FAIL rev_wrap: rev=%0d pulses=%0d want 0 256", rev_count, pulses);
    end
    checks++; if (q !== 8'h00 || rev_done !== 1'b1) begin
      errors++; $display("FAIL rev_wrap_last: q=%h rev_done=%b want 00 1", q, rev_done);
    end
    tick(0, 0, 1, 0, 0);
  endtask

  task automatic test_random();
    logic d = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic c, s, t, sp;
      logic [W-1:0] e;
      c  = ($urandom_range(0, 31) == 0);
      t  = ($urandom_range(0, 7) == 0);
      s  = ($urandom_range(0, 3) == 0);
      sp = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) d = ~d;
      tick(c, s, t, sp, d);
      exp_q.push_back(ring_of(m_phase));
      e = exp_q.pop_front();
      checks++; if (q !== e) begin errors++; $display("FAIL rnd_q[%0d]: got %h want %h", i, q, e); end
      checks++; if (int'(phase) != m_phase) begin
        errors++; $display("FAIL rnd_phase[%0d]: got %0d want %0d", i, phase, m_phase);
      end
      checks++; if (busy !== (m_mode != M_IDLE)) begin
        errors++; $display("FAIL rnd_busy[%0d]: got %b want %b", i, busy, (m_mode != M_IDLE));
      end
      checks++; if (rev_count !== m_rev[RW-1:0] || rev_done !== m_rev_done) begin
        errors++; $display("FAIL rnd_rev[%0d]: rev=%0d done=%b want %0d %b", i, rev_count, rev_done, m_rev, m_rev_done);
      end
      checks++; if (illegal_flag !== 1'b0) begin
        errors++; $display("FAIL rnd_illegal[%0d]: got %b want 0", i, illegal_flag);
      end
    end
    tick(0, 0, 1, 0, 0);
  endtask

`ifdef JSC_ILLEGAL_RECOVERY_EN
  task automatic test_illegal();
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    force dut.q_q = 8'h5A;
    #1;
    release dut.q_q;
    @(posedge clk); #1;
    m_phase = 0; m_mode = M_IDLE; m_rev_done = 1'b0;
    checks++; if (q !== 8'h00 || illegal_flag !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL illegal_recover: q=%h flag=%b busy=%b want 00 1 0", q, illegal_flag, busy);
    end
    tick(0, 0, 0, 0, 0);
    checks++; if (illegal_flag !== 1'b0 || q !== 8'h00) begin
      errors++; $display("FAIL illegal_pulse: flag=%b q=%h want 0 00", illegal_flag, q);
    end
  endtask
`else
  task automatic test_illegal();
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 0, 0, 1);
      checks++; if (illegal_flag !== 1'b0) begin
        errors++; $display("FAIL illegal_tied[%0d]: got %b want 0", i, illegal_flag);
      end
    end
    tick(0, 0, 1, 0, 0);
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_forward_run();
    test_step();
    test_reverse();
    test_stop_hold();
    test_reset_midrun();
    test_rev_wrap();
    test_random();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
